// File: rtl/pipe_skid_reg32_if.sv
// pipe_skid_reg32_if: producer/consumer handshake bundle for the two-entry skid register.
//   slave  : the buffer (takes in_valid/in_data/out_ready/flush, drives in_ready/out_valid/out_data/occupancy)
//   master : the surrounding pipeline stages (the opposite directions)
interface pipe_skid_reg32_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg32.sv
// pipe_skid_reg32: two-entry skid-buffered pipeline register with valid/ready on both sides.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, empties the buffer and zeroes both data registers
//   bus   : slave side of pipe_skid_reg32_if (flush, producer in_*, consumer out_*, occupancy)
// in_ready and out_valid are decoded from the state register alone, so no combinational
// path runs from out_ready to in_ready.
module pipe_skid_reg32 #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    pipe_skid_reg32_if.slave bus
);
    // Encoding equals the held-word count, so occupancy is the state itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign bus.in_ready  = state_q != FULL;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Flush drops everything, including a word accepted this cycle; data is left stale.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        skid_d  = bus.in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: doc/pipe_skid_reg32.md
Name: pipe_skid_reg32

Overview:
- Two-entry skid-buffered pipeline register for the 32-bit MIPS datapath.
- Sits between two pipeline stages and carries a producer/consumer valid/ready handshake in both directions.
- Replaces the unconditional capture-every-clock stage register wherever a downstream stage can stall.
- Breaks the combinational ready path: in_ready is decoded only from internal state, never from out_ready.

Parameters:
- WIDTH, 32, data path width in bits.

Ports:
- clk  input  1  on-board clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- flush  input  1  synchronous pipeline flush; discards all held words.
- in_valid  input  1  producer presents a word on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  head-of-buffer data.
- occupancy  output  2  number of held words: 0, 1 or 2.

Behaviour:
- Storage:
  - main register drives out_data.
  - skid register holds a second word.
  - state register takes one of EMPTY, ONE, FULL.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer completes on the rising edge where its fire term is 1.
- Output decode (from state only):
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy is 0 in EMPTY, 1 in ONE, 2 in FULL.
- Reset (async, any time, including mid-transfer):
  - state = EMPTY, main = 0, skid = 0.
  - Hence out_valid = 0, in_ready = 1, out_data = 0, occupancy = 0.
  - Any word in flight is lost.
- Transitions when flush = 0:
  - EMPTY, in_fire: main <= in_data, go to ONE. Latency is 1 cycle from accept to out_valid.
  - EMPTY, no in_fire: hold.
  - ONE, in_fire and out_fire together: main <= in_data, stay in ONE. Sustains 1 word per cycle.
  - ONE, in_fire only: skid <= in_data, go to FULL. main is unchanged.
  - ONE, out_fire only: go to EMPTY. main keeps its stale value.
  - FULL: in_ready = 0, so no in_fire is possible. On out_fire: main <= skid, go to ONE. Otherwise hold.
- Flush:
  - flush = 1 at an edge forces state to EMPTY, overriding any concurrent in_fire or out_fire.
  - A word presented in that cycle is dropped, although the producer saw in_ready = 1.
  - Data registers are not cleared by flush.
- Ordering and data rules:
  - Strict FIFO order.
  - A word is never duplicated or dropped except by flush or reset.
  - out_data stays stable while out_valid = 1 and out_ready = 0.
  - Data passes bit-exact; there is no arithmetic.
- Input protocol: the producer must hold in_data stable while in_valid = 1 and in_ready = 0. The block does not check this.

Test Plan:
1. Reset and single pass: assert reset mid-cycle -> out_valid = 0, in_ready = 1, out_data = 0, occupancy = 0 without waiting for a clock edge. Release reset, push 0x1234_5678 with out_ready = 1 -> out_valid = 1 next cycle with out_data = 0x1234_5678. It drains the following cycle.
2. Streaming throughput: in_valid = 1 and out_ready = 1 held for 8 cycles with data 1..8 -> output is 1..8 on consecutive cycles, in_ready stays 1, occupancy stays at 1 after the first word.
3. Stall and skid: push 0xA, then hold out_ready = 0 and push 0xB -> occupancy = 2 and in_ready = 0. A further in_valid with 0xC is not accepted and out_data holds 0xA. Raise out_ready -> outputs 0xA, 0xB, 0xC in order.
4. Flush: with FULL holding 0xA, 0xB, assert flush together with out_ready = 1 -> next cycle state = EMPTY, out_valid = 0, in_ready = 1. Neither word is ever delivered.
5. Async reset mid-transfer: with occupancy = 2, assert reset between edges -> outputs clear immediately. After release, a push of 0x5 gives out_data = 0x5 with occupancy = 1.
6. Random valid/ready: randomised 1000-word stream against a scoreboard -> no loss, duplication or reordering, and out_data never changes while out_valid = 1 and out_ready = 0.
